// File: rtl/tt_um_mac_multi.sv
// tt_um_mac_multi: CH independent multiply-accumulate channels behind the
// TinyTapeout user-module pins. Commands arrive one per cycle on uio_in.
// Stage 1 registers the decoded op and the product. Stage 2 commits to the
// accumulators or the readout snapshot. The snapshot is read byte-serially
// on uo_out.
module tt_um_mac_multi #(
  parameter int W     = 8,
  parameter int ACC_W = 20,
  parameter int CH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] CMD_LOAD_A    = 4'd1;
  localparam logic [3:0] CMD_MAC       = 4'd2;
  localparam logic [3:0] CMD_CLEAR     = 4'd3;
  localparam logic [3:0] CMD_READ      = 4'd4;
  localparam logic [3:0] CMD_NEXT      = 4'd5;
  localparam logic [3:0] CMD_SET_MODE  = 4'd6;
  localparam logic [3:0] CMD_CLEAR_ALL = 4'd7;

  // Only the ops that commit at stage 2 are carried down the pipeline.
  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_MAC     = 3'd1,
    OP_CLR     = 3'd2,
    OP_CLR_ALL = 3'd3,
    OP_READ    = 3'd4,
    OP_NEXT    = 3'd5
  } op_e;

  // Product of two W-bit operands, both sign- or zero-extended to 2W bits.
  // The low 2W bits of the extended product are exact in either mode.
  function automatic logic [2*W-1:0] mul_f(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic         sgn);
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;
    if (sgn) begin
      a_ext = {{W{a[W-1]}}, a};
      b_ext = {{W{b[W-1]}}, b};
    end else begin
      a_ext = {{W{1'b0}}, a};
      b_ext = {{W{1'b0}}, b};
    end
    return a_ext * b_ext;
  endfunction

  // Accumulate with overflow detection. Returns {overflow, new_acc}.
  // The sum is formed one bit wider than the accumulator, so the extra bit
  // tells which bound was crossed.
  function automatic logic [ACC_W:0] acc_add_f(input logic [ACC_W-1:0] acc,
                                               input logic [2*W-1:0]   prod,
                                               input logic             sgn,
                                               input logic             sat);
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] clamp;
    logic             ovf;
    prod_ext = ACC_W'(prod);
    if (sgn) begin
      for (int k = 2*W; k < ACC_W; k++) begin
        prod_ext[k] = prod[2*W-1];
      end
      sum = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
      ovf = sum[ACC_W] ^ sum[ACC_W-1];
      if (sum[ACC_W]) begin
        clamp = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        clamp = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      sum   = {1'b0, acc} + {1'b0, prod_ext};
      ovf   = sum[ACC_W];
      clamp = {ACC_W{1'b1}};
    end
    if (ovf && sat) begin
      return {ovf, clamp};
    end else begin
      return {ovf, sum[ACC_W-1:0]};
    end
  endfunction

  logic [3:0]       cmd_s;
  logic [1:0]       ch_s;
  logic             ch_ok_s;
  logic [W-1:0]     b_s;
  op_e              op_next_s;
  logic             load_a_s;
  logic             set_mode_s;
  logic             unused_s;

  logic [W-1:0]     a_r;
  logic             signed_mode_r;
  logic             sat_mode_r;

  op_e              s1_op_r;
  logic [1:0]       s1_ch_r;
  logic [2*W-1:0]   s1_prod_r;
  logic             s1_signed_r;
  logic             s1_sat_r;

  logic [ACC_W-1:0] acc_r [CH];
  logic [CH-1:0]    ovf_r;
  logic [31:0]      snap_r;
  logic             snap_valid_r;
  logic             snap_ovf_r;

  logic [ACC_W-1:0] acc_sel_s;
  logic             ovf_sel_s;
  logic [ACC_W-1:0] mac_res_s;
  logic             mac_ovf_s;

  assign cmd_s    = uio_in[3:0];
  assign ch_s     = uio_in[5:4];
  assign b_s      = ui_in[W-1:0];
  assign ch_ok_s  = (32'(ch_s) < CH);
  assign unused_s = ^{uio_in[7:6], ui_in};

  // Decode the incoming command; deselected or out-of-range ops become NOP.
  always_comb begin
    op_next_s  = OP_NOP;
    load_a_s   = 1'b0;
    set_mode_s = 1'b0;
    if (ena) begin
      case (cmd_s)
        CMD_LOAD_A:    load_a_s   = 1'b1;
        CMD_SET_MODE:  set_mode_s = 1'b1;
        CMD_MAC:       op_next_s  = ch_ok_s ? OP_MAC  : OP_NOP;
        CMD_CLEAR:     op_next_s  = ch_ok_s ? OP_CLR  : OP_NOP;
        CMD_READ:      op_next_s  = ch_ok_s ? OP_READ : OP_NOP;
        CMD_NEXT:      op_next_s  = OP_NEXT;
        CMD_CLEAR_ALL: op_next_s  = OP_CLR_ALL;
        default:       op_next_s  = OP_NOP;
      endcase
    end else begin
      op_next_s = OP_NOP;
    end
  end

  // Operand A and mode bits update directly at the sampling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r           <= {W{1'b0}};
      signed_mode_r <= 1'b0;
      sat_mode_r    <= 1'b0;
    end else begin
      if (load_a_s) begin
        a_r <= b_s;
      end
      if (set_mode_s) begin
        signed_mode_r <= ui_in[0];
        sat_mode_r    <= ui_in[1];
      end
    end
  end

  // Stage 1: capture the op, its channel, the product and the mode in force.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_op_r     <= OP_NOP;
      s1_ch_r     <= 2'd0;
      s1_prod_r   <= {(2*W){1'b0}};
      s1_signed_r <= 1'b0;
      s1_sat_r    <= 1'b0;
    end else begin
      s1_op_r     <= op_next_s;
      s1_ch_r     <= ch_s;
      s1_prod_r   <= mul_f(a_r, b_s, signed_mode_r);
      s1_signed_r <= signed_mode_r;
      s1_sat_r    <= sat_mode_r;
    end
  end

  // Stage 2 operand select reads the live accumulator, so back-to-back ops
  // on one channel see each other without forwarding.
  always_comb begin
    acc_sel_s = {ACC_W{1'b0}};
    ovf_sel_s = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (s1_ch_r == 2'(i)) begin
        acc_sel_s = acc_r[i];
        ovf_sel_s = ovf_r[i];
      end else begin
      end
    end
    {mac_ovf_s, mac_res_s} = acc_add_f(acc_sel_s, s1_prod_r, s1_signed_r, s1_sat_r);
  end

  // Stage 2: commit MAC / CLEAR / CLEAR_ALL to the accumulator bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        acc_r[i] <= {ACC_W{1'b0}};
      end
      ovf_r <= {CH{1'b0}};
    end else begin
      case (s1_op_r)
        OP_MAC: begin
          for (int i = 0; i < CH; i++) begin
            if (s1_ch_r == 2'(i)) begin
              acc_r[i] <= mac_res_s;
              if (mac_ovf_s) begin
                ovf_r[i] <= 1'b1;
              end
            end
          end
        end
        OP_CLR: begin
          for (int i = 0; i < CH; i++) begin
            if (s1_ch_r == 2'(i)) begin
              acc_r[i] <= {ACC_W{1'b0}};
              ovf_r[i] <= 1'b0;
            end
          end
        end
        OP_CLR_ALL: begin
          for (int i = 0; i < CH; i++) begin
            acc_r[i] <= {ACC_W{1'b0}};
          end
          ovf_r <= {CH{1'b0}};
        end
        default: begin
        end
      endcase
    end
  end

  // Stage 2: load or shift the readout snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_r       <= 32'd0;
      snap_valid_r <= 1'b0;
      snap_ovf_r   <= 1'b0;
    end else begin
      case (s1_op_r)
        OP_READ: begin
          snap_r       <= 32'(acc_sel_s);
          snap_ovf_r   <= ovf_sel_s;
          snap_valid_r <= 1'b1;
        end
        OP_NEXT: begin
          if (snap_valid_r) begin
            snap_r <= {8'd0, snap_r[31:8]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign uo_out  = snap_r[7:0];
  assign uio_out = {snap_valid_r, snap_ovf_r, 6'd0};
  assign uio_oe  = 8'hC0;

endmodule

// File: tb/tb_tt_um_mac_multi.sv
// Directed bench for tt_um_mac_multi: a vector table for the basic flows,
// then hand-written sequences for overflow, mode capture, ena, channel
// range and asynchronous reset.
module tb_tt_um_mac_multi;

  localparam logic [3:0] NOP   = 4'd0;
  localparam logic [3:0] LOADA = 4'd1;
  localparam logic [3:0] MAC   = 4'd2;
  localparam logic [3:0] CLR   = 4'd3;
  localparam logic [3:0] READ  = 4'd4;
  localparam logic [3:0] NEXT  = 4'd5;
  localparam logic [3:0] SETM  = 4'd6;
  localparam logic [3:0] CLRA  = 4'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uo_out_c2, uio_out_c2, uio_oe_c2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] cmd;
    logic [1:0] ch;
    logic [7:0] data;
    logic       chk;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  vec_t vecs[$];

  tt_um_mac_multi dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  tt_um_mac_multi #(.W(8), .ACC_W(20), .CH(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out_c2), .uio_out(uio_out_c2), .uio_oe(uio_oe_c2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] cmd, input logic [1:0] ch,
                              input logic [7:0] data, input logic chk,
                              input logic [7:0] exp_uo, input logic [7:0] exp_uio);
    vec_t v;
    v.cmd = cmd; v.ch = ch; v.data = data;
    v.chk = chk; v.exp_uo = exp_uo; v.exp_uio = exp_uio;
    vecs.push_back(v);
  endfunction

  // Drive one command at the falling edge, let it be sampled, return at the next falling edge.
  task automatic step(input logic [3:0] cmd, input logic [1:0] ch, input logic [7:0] data);
    uio_in = {2'b00, ch, cmd};
    ui_in  = data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read1(input string name, input logic [1:0] ch,
                       input logic [7:0] b0, input logic [7:0] uio);
    step(READ, ch, 8'd0);
    step(NOP, 2'd0, 8'd0);
    check({name, " b0"}, uo_out, b0);
    check({name, " uio"}, uio_out, uio);
  endtask

  task automatic read3(input string name, input logic [1:0] ch, input logic [7:0] b0,
                       input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] uio);
    step(READ, ch, 8'd0);
    step(NEXT, 2'd0, 8'd0);
    check({name, " b0"}, uo_out, b0);
    check({name, " uio"}, uio_out, uio);
    step(NEXT, 2'd0, 8'd0);
    check({name, " b1"}, uo_out, b1);
    step(NOP, 2'd0, 8'd0);
    check({name, " b2"}, uo_out, b2);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd0;
    repeat (3) @(negedge clk);
    check("reset uo", uo_out, 8'h00);
    check("reset uio", uio_out, 8'h00);
    check("reset oe", uio_oe, 8'hC0);
    rst_n = 1'b1;

    // Readout after reset.
    add(READ, 2'd0, 8'd0,   1'b0, 8'h00, 8'h00);
    add(NOP,  2'd0, 8'd0,   1'b1, 8'h00, 8'h80);
    // Unsigned: 3 x 200*250 = 0x249F0 on ch1.
    add(LOADA, 2'd0, 8'd200, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) add(MAC, 2'd1, 8'd250, 1'b0, 8'h00, 8'h00);
    add(READ, 2'd1, 8'd0,   1'b0, 8'h00, 8'h00);
    add(NEXT, 2'd0, 8'd0,   1'b1, 8'hF0, 8'h80);
    add(NEXT, 2'd0, 8'd0,   1'b1, 8'h49, 8'h80);
    add(NEXT, 2'd0, 8'd0,   1'b1, 8'h02, 8'h80);
    add(NOP,  2'd0, 8'd0,   1'b1, 8'h00, 8'h80);
    // Signed: -2 * 5 = -10 = 0xFFFF6 on ch2.
    add(SETM, 2'd0, 8'h01,  1'b0, 8'h00, 8'h00);
    add(LOADA, 2'd0, 8'hFE, 1'b0, 8'h00, 8'h00);
    add(MAC,  2'd2, 8'h05,  1'b0, 8'h00, 8'h00);
    add(READ, 2'd2, 8'd0,   1'b0, 8'h00, 8'h00);
    add(NEXT, 2'd0, 8'd0,   1'b1, 8'hF6, 8'h80);
    add(NEXT, 2'd0, 8'd0,   1'b1, 8'hFF, 8'h80);
    add(NEXT, 2'd0, 8'd0,   1'b1, 8'h0F, 8'h80);
    add(NOP,  2'd0, 8'd0,   1'b1, 8'h00, 8'h80);
    // Ordering: MAC, CLEAR, READ -> 0; MAC, READ -> 12; other channels untouched.
    add(SETM, 2'd0, 8'h00,  1'b0, 8'h00, 8'h00);
    add(LOADA, 2'd0, 8'd3,  1'b0, 8'h00, 8'h00);
    add(MAC,  2'd0, 8'd4,   1'b0, 8'h00, 8'h00);
    add(CLR,  2'd0, 8'd0,   1'b0, 8'h00, 8'h00);
    add(READ, 2'd0, 8'd0,   1'b0, 8'h00, 8'h00);
    add(NOP,  2'd0, 8'd0,   1'b1, 8'h00, 8'h80);
    add(MAC,  2'd0, 8'd4,   1'b0, 8'h00, 8'h00);
    add(READ, 2'd0, 8'd0,   1'b0, 8'h00, 8'h00);
    add(NOP,  2'd0, 8'd0,   1'b1, 8'h0C, 8'h80);
    add(READ, 2'd1, 8'd0,   1'b0, 8'h00, 8'h00);
    add(NOP,  2'd0, 8'd0,   1'b1, 8'hF0, 8'h80);
    add(READ, 2'd2, 8'd0,   1'b0, 8'h00, 8'h00);
    add(NOP,  2'd0, 8'd0,   1'b1, 8'hF6, 8'h80);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].cmd, vecs[i].ch, vecs[i].data);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d uo", i), uo_out, vecs[i].exp_uo);
        check($sformatf("vec%0d uio", i), uio_out, vecs[i].exp_uio);
      end
    end

    // Unsigned wrap: 17 * 65025 = 0x10DE11 -> 0x0DE11, flag set.
    step(LOADA, 2'd0, 8'hFF);
    repeat (17) step(MAC, 2'd3, 8'hFF);
    read3("wrap", 2'd3, 8'h11, 8'hDE, 8'h00, 8'hC0);

    // Unsigned saturate: clamps to 0xFFFFF.
    step(CLR, 2'd3, 8'd0);
    step(SETM, 2'd0, 8'h02);
    repeat (17) step(MAC, 2'd3, 8'hFF);
    read3("usat", 2'd3, 8'hFF, 8'hFF, 8'h0F, 8'hC0);

    // Signed saturate at the negative bound: 33 * (-128*127) < -2^19 -> 0x80000.
    step(CLR, 2'd0, 8'd0);
    step(SETM, 2'd0, 8'h03);
    step(LOADA, 2'd0, 8'h80);
    repeat (33) step(MAC, 2'd0, 8'h7F);
    read3("ssat", 2'd0, 8'h00, 8'h00, 8'h08, 8'hC0);

    // Mode is captured with the MAC: a following SET_MODE must not change it.
    step(CLR, 2'd1, 8'd0);
    step(SETM, 2'd0, 8'h01);
    step(LOADA, 2'd0, 8'hFF);
    step(MAC, 2'd1, 8'h01);
    step(SETM, 2'd0, 8'h00);
    read3("mode", 2'd1, 8'hFF, 8'hFF, 8'h0F, 8'h80);

    // ena low: commands ignored, but an op already in stage 1 completes.
    step(CLRA, 2'd0, 8'd0);
    step(LOADA, 2'd0, 8'd7);
    ena = 1'b0;
    step(MAC, 2'd0, 8'd7);
    step(LOADA, 2'd0, 8'd9);
    ena = 1'b1;
    step(MAC, 2'd1, 8'd1);
    step(MAC, 2'd2, 8'd2);
    ena = 1'b0;
    step(NOP, 2'd0, 8'd0);
    ena = 1'b1;
    read1("ena ch0", 2'd0, 8'h00, 8'h80);
    read1("ena ch1", 2'd1, 8'h07, 8'h80);
    read1("ena ch2", 2'd2, 8'h0E, 8'h80);

    // Channel select beyond CH on the 2-channel instance must be ignored.
    step(CLRA, 2'd0, 8'd0);
    step(LOADA, 2'd0, 8'd3);
    step(MAC, 2'd1, 8'd1);
    step(MAC, 2'd3, 8'd4);
    read1("ch1", 2'd1, 8'h03, 8'h80);
    check("c2 ch1 uo", uo_out_c2, 8'h03);
    check("c2 ch1 uio", uio_out_c2, 8'h80);
    read1("ch3", 2'd3, 8'h0C, 8'h80);
    check("c2 ch3 uo", uo_out_c2, 8'h03);

    // Reset with a MAC still in flight: outputs clear at once, MAC discarded.
    step(LOADA, 2'd0, 8'd5);
    uio_in = {4'b0000, MAC};
    ui_in  = 8'd5;
    @(posedge clk);
    uio_in = 8'd0;
    #2 rst_n = 1'b0;
    #1;
    check("async uo", uo_out, 8'h00);
    check("async uio", uio_out, 8'h00);
    check("async oe", uio_oe, 8'hC0);
    @(negedge clk);
    rst_n = 1'b1;
    read1("rstmid ch0", 2'd0, 8'h00, 8'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
